// File: rtl/alu_driver.sv
// alu_driver: issues operand beats to a fixed-latency ALU and buffers results in a credit-protected FIFO.
// Optional build macro ALU_DRV_PERF_CNT_EN adds issued-beat and backpressure counters.
module alu_driver #(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4,
    parameter int ALU_LAT         = 3,
    parameter int RES_FIFO_DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     s_valid_i,
    output logic                                     s_ready_o,
    input  logic                                     s_last_i,
    input  logic [PARALLEL_IF_NUM-1:0][6:0]          s_opmode_i,
    input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] s_a_i,
    input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] s_b_i,
    input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] s_c_i,
    output logic [PARALLEL_IF_NUM-1:0][6:0]          alu_opmode_o,
    output logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] alu_a_o,
    output logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] alu_b_o,
    output logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] alu_c_o,
    output logic                                     alu_stall_o,
    input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] alu_res_i,
    input  logic                                     lane_stall_i,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i,
    output logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] m_data_o,
    output logic                                     m_last_o,
    output logic                                     busy_o
`ifdef ALU_DRV_PERF_CNT_EN
    ,
    output logic [31:0]                              perf_issued_o,
    output logic [31:0]                              perf_bp_o
`endif
);

    // state | meaning
    // IDLE  | no instruction open
    // RUN   | instruction open, final beat not yet accepted
    // DRAIN | final beat accepted, waiting for its result to leave
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int PTR_W = $clog2(RES_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] lanes_t;

    state_t state_q, state_d;

    logic [PARALLEL_IF_NUM-1:0][6:0] alu_opmode_q;
    lanes_t                          alu_a_q, alu_b_q, alu_c_q;

    logic [ALU_LAT:0] tag_v_q, tag_l_q;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    lanes_t           mem_q [RES_FIFO_DEPTH];
    logic             mem_last_q [RES_FIFO_DEPTH];

    logic             accept, push, pop, credit_ok;
    logic [CNT_W:0]   credit_used;

    assign alu_stall_o = lane_stall_i;
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit_ok   = credit_used < (CNT_W+1)'(RES_FIFO_DEPTH);
    assign s_ready_o   = rstn && (state_q != DRAIN) && !lane_stall_i && credit_ok;
    assign accept      = s_valid_i && s_ready_o;
    assign push        = tag_v_q[ALU_LAT] && !alu_stall_o;
    assign m_valid_o   = (count_q != '0);
    assign pop         = m_valid_o && m_ready_i;
    assign m_data_o    = m_valid_o ? mem_q[rd_ptr_q] : '0;
    assign m_last_o    = m_valid_o && mem_last_q[rd_ptr_q];
    assign busy_o      = (state_q != IDLE);

    assign alu_opmode_o = alu_opmode_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_c_o      = alu_c_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = s_last_i ? DRAIN : RUN;
            RUN:     if (accept && s_last_i) state_d = DRAIN;
            DRAIN:   if (pop && m_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({accept, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            alu_opmode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_c_q      <= '0;
            tag_v_q      <= '0;
            tag_l_q      <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (accept) begin
                alu_opmode_q <= s_opmode_i;
                alu_a_q      <= s_a_i;
                alu_b_q      <= s_b_i;
                alu_c_q      <= s_c_i;
            end
            // Stage 0 travels with alu_*_o; stage ALU_LAT lines up with alu_res_i.
            if (!alu_stall_o) begin
                tag_v_q <= {tag_v_q[ALU_LAT-1:0], accept};
                tag_l_q <= {tag_l_q[ALU_LAT-1:0], s_last_i};
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]      <= alu_res_i;
            mem_last_q[wr_ptr_q] <= tag_l_q[ALU_LAT];
        end
    end

`ifdef ALU_DRV_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_bp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issued_q <= '0;
            perf_bp_q     <= '0;
        end else begin
            if (accept && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
            if (s_valid_i && !s_ready_o && (perf_bp_q != '1)) perf_bp_q <= perf_bp_q + 32'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_bp_o     = perf_bp_q;
`endif

endmodule
